// File: rtl/conv1d_ctrl_status_pkg.sv
// Shared register map, bitfield positions and channel state encoding for conv1d_ctrl_status.
package conv1d_ctrl_status_pkg;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_AW-1:0] ADDR_CTRL      = 4'h0;
    localparam logic [REG_AW-1:0] ADDR_STATUS    = 4'h4;
    localparam logic [REG_AW-1:0] ADDR_IRQ_EN    = 4'h8;
    localparam logic [REG_AW-1:0] ADDR_TMO_LIMIT = 4'hC;

    // CTRL fields
    localparam int unsigned START_BASE = 0;
    localparam int unsigned SRST_BASE  = 8;

    // STATUS fields
    localparam int unsigned RUN_BASE  = 0;
    localparam int unsigned DONE_BASE = 8;
    localparam int unsigned TMO_BASE  = 16;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_e;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] wdata;
    } reg_req_t;

endpackage

// File: rtl/conv1d_ctrl_chan.sv
// One accelerator channel: IDLE/RUN state, sticky done/timeout flags, start and soft-reset pulses.
// Optional run-time watchdog is built when CONV1D_CTRL_TIMEOUT_EN is defined.
module conv1d_ctrl_chan
    import conv1d_ctrl_status_pkg::*;
`ifdef CONV1D_CTRL_TIMEOUT_EN
#(
    parameter int unsigned TMO_W = 16
)
`endif
(
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef CONV1D_CTRL_TIMEOUT_EN
    input  logic [TMO_W-1:0] tmo_limit_i,
    input  logic             tmo_clr_i,
`endif
    input  logic             start_req_i,
    input  logic             srst_req_i,
    input  logic             done_clr_i,
    input  logic             acc_done_i,
    output logic             running_o,
    output logic             start_o,
    output logic             chan_rst_o,
    output logic             done_o,
    output logic             timeout_o
);

    chan_state_e state_q;

`ifdef CONV1D_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] cnt_q;
    logic             timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign running_o = (state_q == CH_RUN);

    // Soft reset outranks everything; a hardware set of done/timeout outranks a W1C clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CH_IDLE;
            start_o    <= 1'b0;
            chan_rst_o <= 1'b0;
            done_o     <= 1'b0;
`ifdef CONV1D_CTRL_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            start_o    <= 1'b0;
            chan_rst_o <= 1'b0;
            done_o     <= done_o & ~done_clr_i;
`ifdef CONV1D_CTRL_TIMEOUT_EN
            timeout_q  <= timeout_q & ~tmo_clr_i;
`endif
            if (srst_req_i) begin
                state_q    <= CH_IDLE;
                chan_rst_o <= 1'b1;
                done_o     <= 1'b0;
`ifdef CONV1D_CTRL_TIMEOUT_EN
                timeout_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    CH_IDLE: begin
                        if (start_req_i) begin
                            state_q <= CH_RUN;
                            start_o <= 1'b1;
`ifdef CONV1D_CTRL_TIMEOUT_EN
                            cnt_q   <= TMO_W'(1);
`endif
                        end
                    end
                    CH_RUN: begin
                        if (acc_done_i) begin
                            state_q <= CH_IDLE;
                            done_o  <= 1'b1;
                        end
`ifdef CONV1D_CTRL_TIMEOUT_EN
                        // cnt_q holds the index of the current RUN cycle, starting at 1
                        else if (tmo_limit_i != '0 && cnt_q == tmo_limit_i) begin
                            state_q    <= CH_IDLE;
                            timeout_q  <= 1'b1;
                            chan_rst_o <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + TMO_W'(1);
                        end
`endif
                    end
                    default: state_q <= CH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/conv1d_ctrl_status.sv
// Control/status register block for a multi-channel conv1d accelerator.
// Define CONV1D_CTRL_TIMEOUT_EN to build per-channel RUN watchdogs and the TMO_LIMIT register.
module conv1d_ctrl_status
    import conv1d_ctrl_status_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TMO_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_valid_i,
    input  logic              reg_write_i,
    input  logic [3:0]        reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic [31:0]       reg_rdata_o,
    output logic              reg_ready_o,
    output logic [NUM_CH-1:0] start_o,
    output logic [NUM_CH-1:0] chan_rst_o,
    input  logic [NUM_CH-1:0] acc_done_i,
    output logic              irq_o
);

    reg_req_t          req_c;
    logic              wr_c;
    logic              rd_c;
    logic [NUM_CH-1:0] start_req_c;
    logic [NUM_CH-1:0] srst_req_c;
    logic [NUM_CH-1:0] done_clr_c;
    logic [31:0]       rdata_c;

    logic [NUM_CH-1:0] irq_en_q;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] timeout;

    logic              unused_wdata_c;

    assign req_c = '{valid: reg_valid_i, write: reg_write_i, addr: reg_addr_i, wdata: reg_wdata_i};
    assign wr_c  = req_c.valid &  req_c.write;
    assign rd_c  = req_c.valid & ~req_c.write;

    assign start_req_c = (wr_c && req_c.addr == ADDR_CTRL)   ? req_c.wdata[START_BASE +: NUM_CH] : '0;
    assign srst_req_c  = (wr_c && req_c.addr == ADDR_CTRL)   ? req_c.wdata[SRST_BASE +: NUM_CH]  : '0;
    assign done_clr_c  = (wr_c && req_c.addr == ADDR_STATUS) ? req_c.wdata[DONE_BASE +: NUM_CH]  : '0;

    // Only a subset of the write-data bits is decoded for any given configuration.
    assign unused_wdata_c = ^reg_wdata_i;

`ifdef CONV1D_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_limit_q;
    logic [NUM_CH-1:0] tmo_clr_c;
    assign tmo_clr_c = (wr_c && req_c.addr == ADDR_STATUS) ? req_c.wdata[TMO_BASE +: NUM_CH] : '0;
`else
    logic [TMO_W-1:0]  unused_tmo_limit_c;
    assign unused_tmo_limit_c = '0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        conv1d_ctrl_chan
`ifdef CONV1D_CTRL_TIMEOUT_EN
        #(
            .TMO_W (TMO_W)
        )
`endif
        u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
`ifdef CONV1D_CTRL_TIMEOUT_EN
            .tmo_limit_i (tmo_limit_q),
            .tmo_clr_i   (tmo_clr_c[ch]),
`endif
            .start_req_i (start_req_c[ch]),
            .srst_req_i  (srst_req_c[ch]),
            .done_clr_i  (done_clr_c[ch]),
            .acc_done_i  (acc_done_i[ch]),
            .running_o   (running[ch]),
            .start_o     (start_o[ch]),
            .chan_rst_o  (chan_rst_o[ch]),
            .done_o      (done[ch]),
            .timeout_o   (timeout[ch])
        );
    end

    // Read mux; CTRL and unmapped offsets read as zero.
    always_comb begin
        rdata_c = '0;
        case (req_c.addr)
            ADDR_STATUS: begin
                rdata_c[RUN_BASE +: NUM_CH]  = running;
                rdata_c[DONE_BASE +: NUM_CH] = done;
                rdata_c[TMO_BASE +: NUM_CH]  = timeout;
            end
            ADDR_IRQ_EN: rdata_c[NUM_CH-1:0] = irq_en_q;
`ifdef CONV1D_CTRL_TIMEOUT_EN
            ADDR_TMO_LIMIT: rdata_c[TMO_W-1:0] = tmo_limit_q;
`endif
            default: rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q    <= '0;
            reg_ready_o <= 1'b0;
            reg_rdata_o <= '0;
            irq_o       <= 1'b0;
`ifdef CONV1D_CTRL_TIMEOUT_EN
            tmo_limit_q <= '0;
`endif
        end else begin
            reg_ready_o <= req_c.valid;
            reg_rdata_o <= rd_c ? rdata_c : '0;
            irq_o       <= |((done | timeout) & irq_en_q);
            if (wr_c && req_c.addr == ADDR_IRQ_EN) begin
                irq_en_q <= req_c.wdata[NUM_CH-1:0];
            end
`ifdef CONV1D_CTRL_TIMEOUT_EN
            if (wr_c && req_c.addr == ADDR_TMO_LIMIT) begin
                tmo_limit_q <= req_c.wdata[TMO_W-1:0];
            end
`endif
        end
    end

endmodule

// File: tb/tb_conv1d_ctrl_status.sv
// Directed self-checking bench for conv1d_ctrl_status (NUM_CH=4, TMO_W=16).
module tb_conv1d_ctrl_status;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        reg_valid_i;
    logic        reg_write_i;
    logic [3:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        reg_ready_o;
    logic [3:0]  start_o;
    logic [3:0]  chan_rst_o;
    logic [3:0]  acc_done_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    conv1d_ctrl_status #(
        .NUM_CH (4),
        .TMO_W  (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_ready_o (reg_ready_o),
        .start_o     (start_o),
        .chan_rst_o  (chan_rst_o),
        .acc_done_i  (acc_done_i),
        .irq_o       (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Returns one cycle after the access, i.e. in the cycle where pulses/ready appear.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        tick();
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_wdata_i = '0;
    endtask

    task automatic expect_rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = addr;
        tick();
        check({tag, "_ready"}, 32'(reg_ready_o), 32'h1);
        check(tag, reg_rdata_o, exp);
        reg_valid_i = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] ch);
        acc_done_i = ch;
        tick();
        acc_done_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        acc_done_i  = '0;
        tick();
        tick();
        check("rst_start",   32'(start_o),    32'h0);
        check("rst_chan_rst", 32'(chan_rst_o), 32'h0);
        check("rst_irq",     32'(irq_o),       32'h0);
        check("rst_ready",   32'(reg_ready_o), 32'h0);
        check("rst_rdata",   reg_rdata_o,      32'h0);
        rst_i = 1'b0;
        tick();
        expect_rd("status_init", 4'h4, 32'h0);
        expect_rd("irq_en_init", 4'h8, 32'h0);
        expect_rd("tmo_init",    4'hC, 32'h0);

        // Start channel 0: single pulse, running visible next cycle
        do_write(4'h0, 32'h1);
        check("start_pulse", 32'(start_o), 32'h1);
        check("wr_ready", 32'(reg_ready_o), 32'h1);
        expect_rd("status_run", 4'h4, 32'h1);
        check("start_one_shot", 32'(start_o), 32'h0);
        tick();
        check("ready_drop", 32'(reg_ready_o), 32'h0);
        expect_rd("ctrl_reads_zero", 4'h0, 32'h0);

        // Start while running is ignored
        do_write(4'h0, 32'h1);
        check("start_in_run", 32'(start_o), 32'h0);
        expect_rd("status_still_run", 4'h4, 32'h1);

        // Completion sets sticky done; completion while idle is ignored
        pulse_done(4'b0001);
        expect_rd("status_done", 4'h4, 32'h100);
        pulse_done(4'b1000);
        expect_rd("done_idle_ignored", 4'h4, 32'h100);
        check("irq_disabled", 32'(irq_o), 32'h0);

        // Interrupt enable and W1C clear
        do_write(4'h8, 32'h1);
        check("irq_lag", 32'(irq_o), 32'h0);
        tick();
        check("irq_set", 32'(irq_o), 32'h1);
        expect_rd("irq_en_rb", 4'h8, 32'h1);
        do_write(4'h4, 32'h100);
        check("irq_hold", 32'(irq_o), 32'h1);
        tick();
        check("irq_clear", 32'(irq_o), 32'h0);
        expect_rd("status_w1c", 4'h4, 32'h0);

        // Soft reset wins over start on the same channel
        do_write(4'h0, 32'h101);
        check("srst_pulse", 32'(chan_rst_o), 32'h1);
        check("srst_no_start", 32'(start_o), 32'h0);
        expect_rd("srst_idle", 4'h4, 32'h0);
        check("srst_one_shot", 32'(chan_rst_o), 32'h0);

        // Soft reset clears a set done bit
        do_write(4'h0, 32'h2);
        pulse_done(4'b0010);
        expect_rd("done1", 4'h4, 32'h200);
        do_write(4'h0, 32'h200);
        check("srst1_pulse", 32'(chan_rst_o), 32'h2);
        expect_rd("srst_clears_done", 4'h4, 32'h0);

        // Hardware set beats W1C when coincident
        do_write(4'h0, 32'h2);
        pulse_done(4'b0010);
        do_write(4'h0, 32'h2);
        check("restart_after_done", 32'(start_o), 32'h2);
        expect_rd("done_and_run", 4'h4, 32'h202);
        acc_done_i = 4'b0010;
        do_write(4'h4, 32'h200);
        acc_done_i = '0;
        expect_rd("w1c_vs_set", 4'h4, 32'h200);
        do_write(4'h4, 32'h200);
        expect_rd("w1c_done1", 4'h4, 32'h0);

        // Unmapped offsets
        do_write(4'h2, 32'hFFFF_FFFF);
        check("unmapped_wr_start", 32'(start_o), 32'h0);
        check("unmapped_wr_rst", 32'(chan_rst_o), 32'h0);
        do_write(4'h1, 32'hFFFF_FFFF);
        check("unaligned_wr_start", 32'(start_o), 32'h0);
        expect_rd("unmapped_rd", 4'h2, 32'h0);
        expect_rd("irq_en_kept", 4'h8, 32'h1);
        expect_rd("status_kept", 4'h4, 32'h0);

        // Timeout watchdog
        do_write(4'hC, 32'd10);
`ifdef CONV1D_CTRL_TIMEOUT_EN
        expect_rd("tmo_rb", 4'hC, 32'd10);
        do_write(4'h0, 32'h4);
        check("tmo_start", 32'(start_o), 32'h4);
        for (int i = 2; i <= 10; i++) begin
            tick();
            check("tmo_early", 32'(chan_rst_o), 32'h0);
        end
        tick();
        check("tmo_rst_pulse", 32'(chan_rst_o), 32'h4);
        expect_rd("tmo_status", 4'h4, 32'h40000);
        check("tmo_irq_masked", 32'(irq_o), 32'h0);
        do_write(4'h4, 32'h40000);
        expect_rd("tmo_w1c", 4'h4, 32'h0);
`else
        expect_rd("tmo_rb_off", 4'hC, 32'h0);
        do_write(4'h0, 32'h4);
        check("tmo_start", 32'(start_o), 32'h4);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("no_tmo_rst", 32'(chan_rst_o), 32'h0);
        end
        expect_rd("no_timeout", 4'h4, 32'h4);
        do_write(4'h4, 32'h00FF_0000);
        expect_rd("tmo_w1c_ignored", 4'h4, 32'h4);
        do_write(4'h0, 32'h400);
        check("srst2_pulse", 32'(chan_rst_o), 32'h4);
        expect_rd("srst2_idle", 4'h4, 32'h0);
`endif

        // Reset while channels run
        do_write(4'h0, 32'h1);
        pulse_done(4'b0001);
        do_write(4'h0, 32'h3);
        check("pre_rst_start", 32'(start_o), 32'h3);
        tick();
        check("pre_rst_irq", 32'(irq_o), 32'h1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_start", 32'(start_o), 32'h0);
        check("mid_rst_chan_rst", 32'(chan_rst_o), 32'h0);
        check("mid_rst_irq", 32'(irq_o), 32'h0);
        check("mid_rst_ready", 32'(reg_ready_o), 32'h0);
        check("mid_rst_rdata", reg_rdata_o, 32'h0);
        tick();
        check("post_rst_no_pulse", 32'(chan_rst_o), 32'h0);
        expect_rd("post_rst_status", 4'h4, 32'h0);
        expect_rd("post_rst_irq_en", 4'h8, 32'h0);
        expect_rd("post_rst_tmo", 4'hC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
